// File: rtl/alu_4bit.sv
// Registered ALU for the CPU datapath: computes a result plus carry/zero flags
// from two unsigned operands and captures them one clock after in_valid.
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             out_valid
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  alu_op_e          op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             out_valid_d, out_valid_q;

  assign op       = alu_op_e'(alu_sel);
  // Extended by one bit so the top bit is the carry-out (ADD) or borrow (SUB).
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res   = {a[WIDTH-2:0], 1'b0};
        alu_carry = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, a[WIDTH-1:1]};
        alu_carry = a[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d = alu_res;
      carry_d  = alu_carry;
      zero_d   = (alu_res == '0);
    end
  end

  // Zero resets high so the flag agrees with the cleared result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed arithmetic/logic cases, hold,
// asynchronous reset and a random back-to-back burst against a reference model.
module tb_alu_4bit;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a        = '0;
  logic [WIDTH-1:0] b        = '0;
  logic [2:0]       alu_sel  = '0;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             out_valid;

  int checks = 0;
  int errors = 0;

  int exp_res = 0;
  int exp_c   = 0;
  int exp_z   = 1;

  alu_4bit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model straight from the operation table, using integer arithmetic.
  function automatic void refModel(input int ai, input int bi, input int sel,
                                   output int res, output int cy);
    res = 0;
    cy  = 0;
    case (sel)
      0: begin res = (ai + bi) % MOD;       cy = (ai + bi >= MOD) ? 1 : 0; end
      1: begin res = (ai - bi + MOD) % MOD; cy = (ai < bi) ? 1 : 0; end
      2: res = ai & bi;
      3: res = ai | bi;
      4: res = ai ^ bi;
      5: res = (MOD - 1) - ai;
      6: begin res = (ai * 2) % MOD;        cy = (ai >= MOD / 2) ? 1 : 0; end
      default: begin res = ai / 2;          cy = ai % 2; end
    endcase
  endfunction

  task automatic checkAll(input string tag, input int vld);
    checkOutput({tag, "_result"}, int'(result), exp_res);
    checkOutput({tag, "_carry"}, int'(carry), exp_c);
    checkOutput({tag, "_zero"}, int'(zero), exp_z);
    checkOutput({tag, "_valid"}, int'(out_valid), vld);
  endtask

  // Presents one op; verifies nothing changes before the edge, then the new
  // values appear just after it.
  task automatic applyStimulus(input string tag, input int av, input int bv, input int sv);
    int r, c;
    @(negedge clk);
    in_valid = 1'b1;
    a        = WIDTH'(av);
    b        = WIDTH'(bv);
    alu_sel  = 3'(sv);
    #1;
    checkOutput({tag, "_pre_result"}, int'(result), exp_res);
    refModel(av, bv, sv, r, c);
    exp_res = r;
    exp_c   = c;
    exp_z   = (r == 0) ? 1 : 0;
    @(posedge clk);
    #1;
    checkAll(tag, 1);
  endtask

  task automatic holdIdle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      alu_sel  = 3'($urandom);
      @(posedge clk);
      #1;
      checkAll("hold", 0);
    end
  endtask

  typedef struct {
    string tag;
    int    av;
    int    bv;
    int    sel;
    int    res;
    int    cy;
  } directed_t;

  directed_t dir_tbl[11] = '{
    '{"add_3_2",   3,  2, 0,  5, 0},
    '{"sub_7_4",   7,  4, 1,  3, 0},
    '{"sub_5_5",   5,  5, 1,  0, 0},
    '{"add_15_1", 15,  1, 0,  0, 1},
    '{"sub_2_3",   2,  3, 1, 15, 1},
    '{"and",      12, 10, 2,  8, 0},
    '{"or",       12, 10, 3, 14, 0},
    '{"xor",      12, 10, 4,  6, 0},
    '{"not",      12, 10, 5,  3, 0},
    '{"shl",      12, 10, 6,  8, 1},
    '{"shr",      12, 10, 7,  6, 0}
  };

  initial begin
    // Power-on reset.
    #12;
    exp_res = 0; exp_c = 0; exp_z = 1;
    checkAll("reset_init", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkAll("after_release_idle", 0);

    // Directed table with constant expectations as well as the model.
    foreach (dir_tbl[i]) begin
      applyStimulus(dir_tbl[i].tag, dir_tbl[i].av, dir_tbl[i].bv, dir_tbl[i].sel);
      checkOutput({dir_tbl[i].tag, "_const_res"}, int'(result), dir_tbl[i].res);
      checkOutput({dir_tbl[i].tag, "_const_c"}, int'(carry), dir_tbl[i].cy);
      checkOutput({dir_tbl[i].tag, "_const_z"}, int'(zero), (dir_tbl[i].res == 0) ? 1 : 0);
    end

    holdIdle(3);

    // Back-to-back random burst.
    for (int i = 0; i < 8; i++) begin
      applyStimulus("burst", int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
                    int'($urandom_range(7)));
    end

    // Asynchronous reset mid-cycle while an op is being presented.
    applyStimulus("pre_reset", 9, 3, 2);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 4'd15;
    b        = 4'd1;
    alu_sel  = 3'd0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_res = 0; exp_c = 0; exp_z = 1;
    checkAll("reset_async", 0);
    @(posedge clk);
    #1;
    checkAll("reset_held", 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checkAll("reset_released", 0);

    applyStimulus("post_reset", 6, 6, 1);

    // Longer random run, with occasional idle cycles.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) holdIdle(1);
      else applyStimulus("random", int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
                         int'($urandom_range(7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
